// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared types and constants for the NTT skid buffer
//
// skid_state_t    : buffer occupancy state (EMPTY, BUSY, FULL)
// NTT_STALL_CNT_W : width of the optional stall counter

package ntt_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int NTT_STALL_CNT_W = 16;

endpackage

// File: rtl/ntt_en_reg.sv
// rtl/ntt_en_reg.sv - N-bit register with load enable and async active-low reset
//
// Ports:
//   clk : clock
//   rst : asynchronous active-low reset, clears q to 0
//   en  : load enable
//   d   : data in
//   q   : registered data out

module ntt_en_reg #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ntt_skid_buffer.sv
// rtl/ntt_skid_buffer.sv - two-entry elastic valid/ready pipeline register
//
// Optional feature macro: NTT_SKID_STATS_EN (adds the stall_cnt port).
//
// Ports:
//   clk       : clock
//   rst       : asynchronous active-low reset
//   s_data    : upstream data
//   s_valid   : upstream word present
//   s_ready   : buffer can accept (registered)
//   m_data    : downstream data (registered, main register)
//   m_valid   : m_data holds a valid word (registered)
//   m_ready   : downstream accepts
//   stall_cnt : saturating count of cycles with m_valid && !m_ready
//               (NTT_SKID_STATS_EN only)

module ntt_skid_buffer
    import ntt_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [N-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
`ifdef NTT_SKID_STATS_EN
    ,
    output logic [NTT_STALL_CNT_W-1:0] stall_cnt
`endif
);

    skid_state_t  state;
    skid_state_t  state_nxt;
    logic         in_xfer;
    logic         main_en;
    logic         skid_en;
    logic [N-1:0] main_d;
    logic [N-1:0] skid_q;

    // s_ready is zero in FULL and during the first cycle after reset, so
    // gating with it covers both cases where the input must be ignored.
    assign in_xfer = s_valid && s_ready;

    // When draining from FULL the skid word moves forward; otherwise the
    // main register only ever loads fresh upstream data.
    assign main_d = (state == FULL) ? skid_q : s_data;

    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    main_en   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && m_ready) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    skid_en   = 1'b1;
                    state_nxt = FULL;
                end else if (m_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (m_ready) begin
                    main_en   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they are plain
    // flops with no combinational path from m_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            state   <= state_nxt;
            m_valid <= (state_nxt != EMPTY);
            s_ready <= (state_nxt != FULL);
        end
    end

    ntt_en_reg #(.N(N)) u_main_reg (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (m_data)
    );

    ntt_en_reg #(.N(N)) u_skid_reg (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (s_data),
        .q   (skid_q)
    );

`ifdef NTT_SKID_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_skid_buffer.sv
// tb/tb_ntt_skid_buffer.sv - self-checking bench for ntt_skid_buffer

module tb_ntt_skid_buffer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
`ifdef NTT_SKID_STATS_EN
    logic [15:0]  stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    ntt_skid_buffer #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef NTT_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of accepted words with capacity two.
    logic [N-1:0] q[$];
    logic         exp_s_ready = 1'b0;
    logic [15:0]  exp_stall = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            exp_s_ready = 1'b0;
            exp_stall   = '0;
        end else begin
            logic acc, dep;
            acc = s_valid && exp_s_ready;
            dep = (q.size() > 0) && m_ready;
            if ((q.size() > 0) && !m_ready && (exp_stall != 16'hFFFF))
                exp_stall = exp_stall + 16'd1;
            if (dep) void'(q.pop_front());
            if (acc) q.push_back(s_data);
            exp_s_ready = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_ready", 32'(s_ready), 32'(exp_s_ready));
            chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
            if (q.size() > 0) chk("m_data", 32'(m_data), 32'(q[0]));
            if (!rst) chk("m_data_rst", 32'(m_data), 32'd0);
`ifdef NTT_SKID_STATS_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
        end
    end

    // Inputs change just after a rising edge, then one edge is consumed.
    task automatic step(input logic sv, input logic [N-1:0] d, input logic mr);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        chk_en = 1'b1;
        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_after_rst", 32'(s_ready), 32'd1);

        // Streaming 0x01..0x10 with m_ready high.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, N'(i), 1'b1);
            chk("stream_data", 32'(m_data), 32'(i));
            chk("stream_s_ready", 32'(s_ready), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("stream_drained", 32'(m_valid), 32'd0);

        // Backpressure.
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        chk("bp_m_data", 32'(m_data), 32'hA1);
        step(1'b1, 8'hEE, 1'b0);
        chk("bp_stable", 32'(m_data), 32'hA1);
        step(1'b0, 8'h00, 1'b1);
        chk("bp_drain2", 32'(m_data), 32'hA2);
        chk("bp_s_ready_back", 32'(s_ready), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("bp_empty", 32'(m_valid), 32'd0);

        // Random stress.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)));
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("stress_drained", 32'(m_valid), 32'd0);

        // Mid-operation reset while FULL with 0x33/0x44.
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        chk("mid_full", 32'(s_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_m_data", 32'(m_data), 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h55, 1'b1);
        chk("post_rst_data", 32'(m_data), 32'h55);
        chk("post_rst_valid", 32'(m_valid), 32'd1);
        step(1'b0, 8'h00, 1'b1);

`ifdef NTT_SKID_STATS_EN
        step(1'b1, 8'h77, 1'b0);
        s_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        #2;
        rst = 1'b0;
        #1;
        chk("stall_rst", 32'(stall_cnt), 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
